iterative_mdu: RTL and testbench

- Parametrised multi-cycle multiply/divide unit for the execute stage; extends the single-cycle ALU operation set with the RV32M operations.
- Uses a radix-2 shift-add multiplier and a restoring divider sharing one 2*DATA_WIDTH datapath.
- Handshake: Start/Busy/Done. The hazard unit stalls the pipeline while Busy is high.

---
 rtl/iterative_mdu.sv | 165 ++++++++++++++++
 tb/tb_iterative_mdu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_mdu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iterative_mdu : RV32M multiply/divide, radix-2 shift-add / restoring div |
// | Optional macro MDU_EARLY_OUT_EN: zero / overflow operands skip iteration |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module iterative_mdu #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic                  Flush,
  input  logic [2:0]            MDUControl,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  ZeroFlag,
  output logic                  NegativeFlag
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [W-1:0]         opnd_q, opnd_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic [W-1:0]         result_q, result_d;
  logic                 done_q, done_d;

  logic         a_signed, b_signed, a_neg, b_neg, a_zero, b_zero, is_div, div_ovf;
  logic [W-1:0] a_abs, b_abs;

  always_comb begin
    is_div   = MDUControl[2];
    a_signed = (MDUControl != 3'b011) && (MDUControl != 3'b101) && (MDUControl != 3'b111);
    b_signed = a_signed && (MDUControl != 3'b010);
    a_neg    = a_signed & SrcA[W-1];
    b_neg    = b_signed & SrcB[W-1];
    a_abs    = a_neg ? -SrcA : SrcA;
    b_abs    = b_neg ? -SrcB : SrcB;
    a_zero   = (SrcA == '0);
    b_zero   = (SrcB == '0);
    div_ovf  = is_div & ~MDUControl[0] & (SrcA == {1'b1, {(W-1){1'b0}}}) & (&SrcB);
  end

  // acc holds {high, low} of the product, or {remainder, quotient} while dividing
  logic [W:0]     mul_sum, div_diff;
  logic [2*W:0]   div_sh;
  logic [2*W-1:0] mul_next, div_next, prod;
  logic [W-1:0]   mul_res, div_raw, div_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    mul_next = {mul_sum, acc_q[W-1:1]};
    div_sh   = {acc_q, 1'b0};
    div_diff = div_sh[2*W:W] - {1'b0, opnd_q};
    div_next = div_diff[W] ? div_sh[2*W-1:0] : {div_diff[W-1:0], div_sh[W-1:1], 1'b1};
    prod     = neg_q ? -acc_q : acc_q;
    mul_res  = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    div_raw  = op_q[1] ? acc_q[2*W-1:W] : acc_q[W-1:0];
    div_res  = neg_q ? -div_raw : div_raw;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = CALC;
          cnt_d   = CNT_WIDTH'(W);
          op_d    = MDUControl;
          if (is_div) begin
            opnd_d = b_abs;
            acc_d  = {{W{1'b0}}, a_abs};
            // a zero divisor yields all-ones quotient regardless of dividend sign
            neg_d  = MDUControl[1] ? a_neg : ((a_neg ^ b_neg) & ~b_zero);
          end else begin
            opnd_d = a_abs;
            acc_d  = {{W{1'b0}}, b_abs};
            neg_d  = a_neg ^ b_neg;
          end
`ifdef MDU_EARLY_OUT_EN
          if (a_zero | b_zero | div_ovf) begin
            state_d = FIX;
            cnt_d   = '0;
            if (is_div & b_zero)
              acc_d = {a_abs, {W{1'b1}}};
            else if (div_ovf)
              acc_d = {{W{1'b0}}, a_abs};
            else
              acc_d = '0;
          end
`endif
        end
      end
      CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1))
          state_d = FIX;
      end
      FIX: begin
        result_d = op_q[2] ? div_res : mul_res;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (Flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign Busy         = (state_q != IDLE);
  assign Done         = done_q;
  assign Result       = result_q;
  assign ZeroFlag     = (result_q == '0);
  assign NegativeFlag = result_q[W-1];

endmodule
`default_nettype wire

// File: tb/tb_iterative_mdu.sv
`default_nettype none
// Bench for iterative_mdu: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_iterative_mdu;

  localparam int W    = 32;
  localparam int NLAT = W + 1;
`ifdef MDU_EARLY_OUT_EN
  localparam int ELAT = 1;
`else
  localparam int ELAT = NLAT;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         Start = 1'b0;
  logic         Flush = 1'b0;
  logic [2:0]   MDUControl = 3'b000;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         Busy, Done, ZeroFlag, NegativeFlag;
  logic [W-1:0] Result;

  int checks = 0;
  int errors = 0;

  iterative_mdu #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Start       (Start),
    .Flush       (Flush),
    .MDUControl  (MDUControl),
    .SrcA        (SrcA),
    .SrcB        (SrcB),
    .Busy        (Busy),
    .Done        (Done),
    .Result      (Result),
    .ZeroFlag    (ZeroFlag),
    .NegativeFlag(NegativeFlag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V M semantics from plain 64-bit arithmetic
  function automatic logic [W-1:0] ref_mdu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
`ifdef MDU_EARLY_OUT_EN
    if (a == 0 || b == 0 || (op[2] && !op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))
      return 1;
`endif
    return NLAT;
  endfunction

  // Transaction-level model: tracks the in-flight op and the edge its result lands
  int           cyc = 0;
  bit           m_pending = 1'b0;
  int           m_done_edge = 0;
  int           m_done_cyc = -1;
  logic [W-1:0] m_exp = '0;
  logic [W-1:0] m_held = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_pending = 1'b0; m_done_edge = 0; m_done_cyc = -1;
      m_exp = '0; m_held = '0;
    end else begin
      cyc = cyc + 1;
      if (Flush) begin
        m_pending = 1'b0;
      end else if (m_pending) begin
        if (cyc == m_done_edge) begin
          m_held = m_exp; m_pending = 1'b0; m_done_cyc = cyc;
        end
      end else if (Start) begin
        m_pending   = 1'b1;
        m_done_edge = cyc + exp_lat(MDUControl, SrcA, SrcB);
        m_exp       = ref_mdu(MDUControl, SrcA, SrcB);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", Busy, m_pending);
      chk("done", Done, m_done_cyc == cyc);
      chk("result", Result, m_held);
      chk("zero_flag", ZeroFlag, m_held == '0);
      chk("neg_flag", NegativeFlag, m_held[W-1]);
    end
  end

  task automatic wait_done(output int edges, output int busy_cyc);
    edges = 0; busy_cyc = 0;
    while (edges < 200) begin
      @(negedge clk);
      if (Done) break;
      if (Busy) busy_cyc++;
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_res, input int exp_edges);
    int edges, busy_cyc;
    @(posedge clk); #1;
    MDUControl = op; SrcA = a; SrcB = b; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom; MDUControl = 3'($urandom);
    wait_done(edges, busy_cyc);
    chk({name, "_latency"}, edges, exp_edges);
    chk({name, "_busy_cycles"}, busy_cyc, exp_edges);
    chk({name, "_result"}, Result, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int edges, busy_cyc, done_seen;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_result", Result, 0);
    chk("rst_zero", ZeroFlag, 1);
    chk("rst_neg", NegativeFlag, 0);
    rst_n = 1'b1;

    do_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, NLAT);
    chk("mul_negflag", NegativeFlag, 1);
    do_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, NLAT);
    do_op("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, NLAT);
    do_op("mulhsu_max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, NLAT);
    do_op("mulh_-1x5", 3'b001, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, NLAT);
    do_op("mul_0x5", 3'b000, 32'd0, 32'd5, 32'd0, ELAT);
    do_op("div_-7_2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, NLAT);
    do_op("rem_-7_2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, NLAT);
    do_op("div_7_-2", 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, NLAT);
    do_op("rem_7_-2", 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, NLAT);
    do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, NLAT);
    do_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, NLAT);
    do_op("div_0_5", 3'b100, 32'd0, 32'd5, 32'd0, ELAT);
    do_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, ELAT);
    do_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, ELAT);
    chk("rem_ovf_zeroflag", ZeroFlag, 1);
    do_op("div_-9_0", 3'b100, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFFF, ELAT);
    do_op("rem_-9_0", 3'b110, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, ELAT);
    do_op("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, ELAT);
    do_op("remu_5_0", 3'b111, 32'd5, 32'd0, 32'd5, ELAT);

    // Flush mid-divide: no Done, Result keeps 5
    @(posedge clk); #1;
    MDUControl = 3'b100; SrcA = 32'd100; SrcB = 32'd3; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge clk);
    #1; Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    chk("flush_busy", Busy, 0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) done_seen++;
    end
    chk("flush_no_done", done_seen, 0);
    chk("flush_result_kept", Result, 32'd5);

    // Flush beats Start in the same cycle
    @(posedge clk); #1;
    MDUControl = 3'b000; SrcA = 32'd2; SrcB = 32'd2; Start = 1'b1; Flush = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'b0;
    chk("flush_blocks_start", Busy, 0);

    // Start held while busy, operands changed after acceptance
    @(posedge clk); #1;
    MDUControl = 3'b101; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
    @(posedge clk); #1;
    MDUControl = 3'b000; SrcA = 32'd1000; SrcB = 32'd3;
    repeat (5) @(posedge clk);
    #1; Start = 1'b0;
    wait_done(edges, busy_cyc);
    chk("held_start_latency", edges, NLAT - 5);
    chk("held_start_result", Result, 32'd14);

    // Back-to-back: Start issued in the Done cycle
    @(posedge clk); #1;
    MDUControl = 3'b011; SrcA = 32'hFFFFFFFF; SrcB = 32'hFFFFFFFF; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (NLAT) @(posedge clk);
    #1;
    chk("b2b_first_done", Done, 1);
    chk("b2b_first_result", Result, 32'hFFFFFFFE);
    MDUControl = 3'b111; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    wait_done(edges, busy_cyc);
    chk("b2b_second_latency", edges, NLAT);
    chk("b2b_second_result", Result, 32'd2);

    // Asynchronous reset mid-CALC
    @(posedge clk); #1;
    MDUControl = 3'b000; SrcA = 32'd7; SrcB = 32'd9; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (5) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    chk("arst_busy", Busy, 0);
    chk("arst_done", Done, 0);
    chk("arst_result", Result, 0);
    #3; rst_n = 1'b1;
    do_op("mul_3x4_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, NLAT);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
